// File: rtl/pll_nco_pkg.sv
// Shared types and helpers for the NCO clock-enable generator.
//   state_e   : controller state (IDLE, SETTLE, LOCKED)
//   nco_cfg_t : per-channel configuration record {ftw, phase} at the widest supported ACC_W
//   idx_width : select/counter width for n items, never less than one bit
package pll_nco_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int unsigned MAX_ACC_W = 48;

  typedef struct packed {
    logic [MAX_ACC_W-1:0] ftw;
    logic [MAX_ACC_W-1:0] phase;
  } nco_cfg_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nco_channel.sv
// One NCO channel: shadow config, active FTW, phase accumulator and registered outputs.
// Ports:
//   refclk, rst       : clock and synchronous active-high reset
//   wr_en             : shadow write for this channel (handshake already qualified)
//   wr_ftw, wr_phase  : shadow write data
//   apply             : commit shadows to the active registers and restart the accumulator
//   clk_en            : one-cycle strobe in the cycle the wrapped accumulator value appears
//   clk_sq            : accumulator MSB, registered
module nco_channel #(
  parameter int unsigned ACC_W = 32
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ACC_W-1:0] wr_ftw,
  input  logic [ACC_W-1:0] wr_phase,
  input  logic             apply,
  output logic             clk_en,
  output logic             clk_sq
);

  logic [ACC_W-1:0] shadow_ftw_q, shadow_phase_q;
  logic [ACC_W-1:0] active_ftw_q, acc_q;
  logic [ACC_W-1:0] load_ftw, load_phase;
  logic [ACC_W:0]   sum;
  logic             clk_en_q, clk_sq_q;

  // Write-through so a write landing with apply is the value that gets committed.
  assign load_ftw   = wr_en ? wr_ftw   : shadow_ftw_q;
  assign load_phase = wr_en ? wr_phase : shadow_phase_q;

  // Extra bit keeps the wrap carry.
  assign sum = {1'b0, acc_q} + {1'b0, active_ftw_q};

  always_ff @(posedge refclk) begin
    if (rst) begin
      shadow_ftw_q   <= '0;
      shadow_phase_q <= '0;
      active_ftw_q   <= '0;
      acc_q          <= '0;
      clk_en_q       <= 1'b0;
      clk_sq_q       <= 1'b0;
    end else begin
      if (wr_en) begin
        shadow_ftw_q   <= wr_ftw;
        shadow_phase_q <= wr_phase;
      end
      if (apply) begin
        // Load cycle: no strobe, square wave follows the new phase immediately.
        active_ftw_q <= load_ftw;
        acc_q        <= load_phase;
        clk_en_q     <= 1'b0;
        clk_sq_q     <= load_phase[ACC_W-1];
      end else begin
        acc_q    <= sum[ACC_W-1:0];
        clk_en_q <= sum[ACC_W];
        clk_sq_q <= sum[ACC_W-1];
      end
    end
  end

  assign clk_en = clk_en_q;
  assign clk_sq = clk_sq_q;

endmodule

// File: rtl/pll_nco_clkgen.sv
// Multi-channel NCO clock-enable generator with shadow/apply config and a lock indicator.
// Ports:
//   refclk, rst            : clock and synchronous active-high reset
//   cfg_valid/cfg_ready    : shadow write handshake
//   cfg_ch, cfg_ftw, cfg_phase : write target channel and data (cfg_ch >= NUM_CH is dropped)
//   cfg_apply              : commit all shadows and restart every channel phase-coherently
//   clk_en, clk_sq         : per-channel strobe and square wave
//   locked                 : high once SETTLE_CYCLES have elapsed since the last apply
module pll_nco_clkgen
  import pll_nco_pkg::*;
#(
  parameter int unsigned  NUM_CH        = 3,
  parameter int unsigned  ACC_W         = 32,
  parameter int unsigned  SETTLE_CYCLES = 64,
  localparam int unsigned CH_W          = idx_width(NUM_CH)
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_ftw,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic              cfg_apply,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] clk_sq,
  output logic              locked
);

  localparam int unsigned CNT_W = idx_width(SETTLE_CYCLES);

  state_e           state_q;
  logic [CNT_W-1:0] settle_cnt_q;
  logic             locked_q, ready_q;
  logic             wr_fire, apply_fire;

  // ready_q is low exactly while settling, which is also when apply is ignored.
  assign wr_fire    = cfg_valid && ready_q;
  assign apply_fire = cfg_apply && ready_q;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      locked_q     <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE, LOCKED: begin
          if (apply_fire) begin
            state_q      <= SETTLE;
            settle_cnt_q <= '0;
            locked_q     <= 1'b0;
            ready_q      <= 1'b0;
          end
        end
        SETTLE: begin
          if (settle_cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
            ready_q  <= 1'b1;
          end else begin
            settle_cnt_q <= settle_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q      <= IDLE;
          settle_cnt_q <= '0;
          locked_q     <= 1'b0;
          ready_q      <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready = ready_q;
  assign locked    = locked_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    nco_channel #(
      .ACC_W(ACC_W)
    ) u_ch (
      .refclk   (refclk),
      .rst      (rst),
      .wr_en    (wr_fire && (cfg_ch == CH_W'(i))),
      .wr_ftw   (cfg_ftw),
      .wr_phase (cfg_phase),
      .apply    (apply_fire),
      .clk_en   (clk_en[i]),
      .clk_sq   (clk_sq[i])
    );
  end

endmodule

// File: tb/tb_pll_nco_clkgen.sv
module tb_pll_nco_clkgen;
  import pll_nco_pkg::*;

  localparam int unsigned NUM_CH        = 3;
  localparam int unsigned ACC_W         = 8;
  localparam int unsigned SETTLE_CYCLES = 4;
  localparam int unsigned CH_W          = 2;

  logic              refclk = 1'b0;
  logic              rst, cfg_valid, cfg_ready, cfg_apply, locked;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_ftw, cfg_phase;
  logic [NUM_CH-1:0] clk_en, clk_sq;

  int checks = 0;
  int errors = 0;

  pll_nco_clkgen #(
    .NUM_CH       (NUM_CH),
    .ACC_W        (ACC_W),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_ftw  (cfg_ftw),
    .cfg_phase(cfg_phase),
    .cfg_apply(cfg_apply),
    .clk_en   (clk_en),
    .clk_sq   (clk_sq),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  // Reference model: each channel's accumulator is phase + ftw * (cycles since load),
  // evaluated in closed form; lock is purely a function of cycles since the last apply.
  nco_cfg_t m_shadow [NUM_CH];
  longint   m_act    [NUM_CH];
  longint   m_phase  [NUM_CH];
  longint   m_ld     [NUM_CH];
  longint   cyc     = 0;
  longint   m_apply = 0;
  bit       m_idle  = 1'b1;

  function automatic bit m_settling();
    return !m_idle && ((cyc - m_apply) < SETTLE_CYCLES);
  endfunction

  function automatic logic [NUM_CH-1:0] exp_en();
    logic [NUM_CH-1:0] e;
    for (int c = 0; c < NUM_CH; c++) begin
      longint v = m_phase[c] + m_act[c] * (cyc - m_ld[c]);
      e[c] = (cyc > m_ld[c]) && ((v >> ACC_W) != ((v - m_act[c]) >> ACC_W));
    end
    return e;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_sq();
    logic [NUM_CH-1:0] s;
    for (int c = 0; c < NUM_CH; c++) begin
      longint v = (m_phase[c] + m_act[c] * (cyc - m_ld[c])) % 256;
      s[c] = v >= 128;
    end
    return s;
  endfunction

  function automatic logic exp_locked();
    return !m_idle && ((cyc - m_apply) >= SETTLE_CYCLES);
  endfunction

  task automatic model_edge();
    bit rdy;
    rdy = !m_settling();
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_shadow[c] = '0;
        m_act[c]    = 0;
        m_phase[c]  = 0;
        m_ld[c]     = cyc + 1;
      end
      m_idle  = 1'b1;
      m_apply = 0;
    end else begin
      if (cfg_valid && rdy && (int'(cfg_ch) < NUM_CH)) begin
        m_shadow[cfg_ch].ftw   = MAX_ACC_W'(cfg_ftw);
        m_shadow[cfg_ch].phase = MAX_ACC_W'(cfg_phase);
      end
      if (cfg_apply && rdy) begin
        for (int c = 0; c < NUM_CH; c++) begin
          m_act[c]   = longint'(m_shadow[c].ftw);
          m_phase[c] = longint'(m_shadow[c].phase);
          m_ld[c]    = cyc + 1;
        end
        m_idle  = 1'b0;
        m_apply = cyc + 1;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge refclk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0;
    cfg_apply = 1'b0;
    cfg_ch    = '0;
    cfg_ftw   = '0;
    cfg_phase = '0;
  endtask

  task automatic cfg_write(input int ch, input int ftw, input int ph);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_ftw   = ACC_W'(ftw);
    cfg_phase = ACC_W'(ph);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_apply(output longint ta);
    cfg_apply = 1'b1;
    tick();
    cfg_apply = 1'b0;
    ta = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({clk_en, clk_sq, locked, cfg_ready} !== {3'b000, 3'b000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: got en=%b sq=%b lk=%b rdy=%b, want en=000 sq=000 lk=0 rdy=1",
               clk_en, clk_sq, locked, cfg_ready);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({clk_en, clk_sq, locked, cfg_ready} !== {3'b000, 3'b000, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL idle cyc=%0d: got en=%b sq=%b lk=%b rdy=%b, want en=000 sq=000 lk=0 rdy=1",
                 cyc, clk_en, clk_sq, locked, cfg_ready);
      end
    end
  endtask

  task automatic test_three_channel();
    longint ta;
    logic [NUM_CH-1:0] d;
    cfg_write(0, 64, 0);
    cfg_write(1, 64, 128);
    cfg_write(2, 128, 0);
    do_apply(ta);
    for (int k = 0; k < 20; k++) begin
      d[0] = (k >= 4) && (k % 4 == 0);
      d[1] = (k % 4 == 2);
      d[2] = (k >= 2) && (k % 2 == 0);
      checks++;
      if ({clk_en, locked} !== {d, 1'(k >= 4)} ||
          {clk_en, clk_sq, locked, cfg_ready} !==
          {exp_en(), exp_sq(), exp_locked(), !m_settling()}) begin
        errors++;
        $display("FAIL three_ch k=%0d: got en=%b sq=%b lk=%b rdy=%b, want en=%b sq=%b lk=%b rdy=%b",
                 k, clk_en, clk_sq, locked, cfg_ready, exp_en(), exp_sq(), exp_locked(),
                 !m_settling());
      end
      if (k == 0) begin
        checks++;
        if (clk_sq[1] !== 1'b1) begin
          errors++;
          $display("FAIL sq1_at_load: got %b, want 1", clk_sq[1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_settle_write();
    longint ta;
    do_apply(ta);
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_ftw   = 8'd16;
    cfg_phase = 8'd0;
    for (int k = 0; k <= int'(SETTLE_CYCLES); k++) begin
      checks++;
      if (cfg_ready !== 1'(k >= int'(SETTLE_CYCLES)) ||
          {clk_en, clk_sq, locked} !== {exp_en(), exp_sq(), exp_locked()}) begin
        errors++;
        $display("FAIL settle_write k=%0d: got en=%b sq=%b lk=%b rdy=%b, want en=%b sq=%b lk=%b rdy=%b",
                 k, clk_en, clk_sq, locked, cfg_ready, exp_en(), exp_sq(), exp_locked(),
                 k >= int'(SETTLE_CYCLES));
      end
      tick();
    end
    cfg_valid = 1'b0;
    do_apply(ta);
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (clk_en[0] !== 1'((k >= 16) && (k % 16 == 0)) ||
          {clk_en, clk_sq, locked, cfg_ready} !==
          {exp_en(), exp_sq(), exp_locked(), !m_settling()}) begin
        errors++;
        $display("FAIL settle_commit k=%0d: got en=%b sq=%b lk=%b rdy=%b, want en=%b sq=%b lk=%b rdy=%b",
                 k, clk_en, clk_sq, locked, cfg_ready, exp_en(), exp_sq(), exp_locked(),
                 !m_settling());
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    longint ta;
    // Write and apply in the same cycle: the new ftw must be the committed one.
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_ftw   = 8'd32;
    cfg_phase = 8'd0;
    do_apply(ta);
    cfg_valid = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 20; k++) begin
        checks++;
        if (clk_en[0] !== 1'((k >= 8) && (k % 8 == 0)) ||
            {clk_en, clk_sq, locked, cfg_ready} !==
            {exp_en(), exp_sq(), exp_locked(), !m_settling()}) begin
          errors++;
          $display("FAIL b2b pass=%0d k=%0d: got en=%b sq=%b lk=%b rdy=%b, want en=%b sq=%b lk=%b rdy=%b",
                   pass, k, clk_en, clk_sq, locked, cfg_ready, exp_en(), exp_sq(), exp_locked(),
                   !m_settling());
        end
        tick();
      end
      if (pass == 0) begin
        checks++;
        if (cfg_ready !== 1'b1) begin
          errors++;
          $display("FAIL ch3_ready: got %b, want 1", cfg_ready);
        end
        cfg_write(3, 1, 1);
        do_apply(ta);
      end
    end
  endtask

  task automatic test_reset_locked();
    longint ta;
    do_apply(ta);
    for (int k = 0; k < int'(SETTLE_CYCLES) + 2; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({clk_en, clk_sq, locked, cfg_ready} !== {3'b000, 3'b000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_locked: got en=%b sq=%b lk=%b rdy=%b, want en=000 sq=000 lk=0 rdy=1",
               clk_en, clk_sq, locked, cfg_ready);
    end
    do_apply(ta);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if ({clk_en, clk_sq} !== 6'b0 || locked !== 1'(k >= int'(SETTLE_CYCLES)) ||
          cfg_ready !== !m_settling()) begin
        errors++;
        $display("FAIL zero_apply k=%0d: got en=%b sq=%b lk=%b rdy=%b, want en=000 sq=000 lk=%b",
                 k, clk_en, clk_sq, locked, cfg_ready, k >= int'(SETTLE_CYCLES));
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_apply = ($urandom_range(0, 11) == 0);
      cfg_ch    = CH_W'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       cfg_ftw = 8'd0;
        1:       cfg_ftw = ACC_W'($urandom_range(128, 255));
        default: cfg_ftw = ACC_W'($urandom_range(1, 127));
      endcase
      cfg_phase = ACC_W'($urandom);
      tick();
      checks++;
      if ({clk_en, clk_sq, locked, cfg_ready} !==
          {exp_en(), exp_sq(), exp_locked(), !m_settling()}) begin
        errors++;
        $display("FAIL random i=%0d: got en=%b sq=%b lk=%b rdy=%b, want en=%b sq=%b lk=%b rdy=%b",
                 i, clk_en, clk_sq, locked, cfg_ready, exp_en(), exp_sq(), exp_locked(),
                 !m_settling());
      end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_three_channel();
    test_settle_write();
    test_back_to_back();
    test_reset_locked();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
